// File: rtl/cmp_pkg.sv
// Shared types and constants for the comparator sweep engine.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package cmp_pkg;

  // Sweep controller states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } cmp_state_t;

  // Comparator result triple, packed as {gt, eq, lt}.
  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } cmp_res_t;

  // Default operand width; instantiations override WIDTH as needed.
  localparam int DEF_WIDTH = 2;

  // Number of (a, b) vectors in a full sweep at the default width.
  localparam int NVEC = 1 << (2 * DEF_WIDTH);

  // Number of (a, b) vectors in a full sweep at an arbitrary width.
  function automatic int nvec(input int width);
    return 1 << (2 * width);
  endfunction

endpackage

// File: rtl/cmp_golden.sv
// Golden magnitude comparator: reference {gt, eq, lt} for an operand pair.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow the inputs continuously.
module cmp_golden #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             exp_gt,
  output logic             exp_eq,
  output logic             exp_lt
);

  // Unsigned magnitude compare of the two operands.
  always_comb begin
    exp_gt = (a > b);
    exp_eq = (a == b);
    exp_lt = (a < b);
  end

endmodule

// File: rtl/cmp_sweep_driver.sv
// Exhaustive (a, b) sweep of an external comparator, checked against cmp_golden.
// Latency: SETTLE+1 cycles per vector; done rises (SETTLE+1)*2^(2*WIDTH) edges after start.
// Backpressure: none; start is ignored while busy, results hold in DONE until start or reset.
module cmp_sweep_driver
  import cmp_pkg::*;
#(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  input  logic               dut_gt,
  input  logic               dut_eq,
  input  logic               dut_lt,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic [WIDTH-1:0]   first_fail_a,
  output logic [WIDTH-1:0]   first_fail_b
);

  localparam int IW = 2 * WIDTH;
  // Counter only needs to hold SETTLE-1; keep at least one bit so it always exists.
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((SETTLE > 0) ? SETTLE - 1 : 0);

  cmp_state_t        state, state_nxt;
  logic [IW-1:0]     idx, idx_nxt;
  logic [IW:0]       err_nxt;
  logic [WIDTH-1:0]  ffa_nxt, ffb_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;

  cmp_res_t exp_res;
  cmp_res_t dut_res;
  logic     mismatch;

  // Operands come straight off the registered vector index.
  assign a = idx[IW-1:WIDTH];
  assign b = idx[WIDTH-1:0];

  cmp_golden #(.WIDTH(WIDTH)) u_golden (
    .a      (a),
    .b      (b),
    .exp_gt (exp_res.gt),
    .exp_eq (exp_res.eq),
    .exp_lt (exp_res.lt)
  );

  assign dut_res  = '{gt: dut_gt, eq: dut_eq, lt: dut_lt};
  assign mismatch = (dut_res != exp_res);

  assign busy = (state == ST_SETTLE) || (state == ST_CHECK);
  assign done = (state == ST_DONE);
  assign pass = done && (err_count == '0);

  // State and datapath registers; reset discards any partial sweep.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      idx          <= '0;
      err_count    <= '0;
      first_fail_a <= '0;
      first_fail_b <= '0;
      cnt          <= '0;
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      err_count    <= err_nxt;
      first_fail_a <= ffa_nxt;
      first_fail_b <= ffb_nxt;
      cnt          <= cnt_nxt;
    end
  end

  // Next-state and datapath updates for the sweep sequencer.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    err_nxt   = err_count;
    ffa_nxt   = first_fail_a;
    ffb_nxt   = first_fail_b;
    cnt_nxt   = cnt;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          idx_nxt = '0;
          err_nxt = '0;
          ffa_nxt = '0;
          ffb_nxt = '0;
          if (SETTLE == 0) begin
            state_nxt = ST_CHECK;
          end else begin
            state_nxt = ST_SETTLE;
            cnt_nxt   = CNT_INIT;
          end
        end
      end

      ST_SETTLE: begin
        if (cnt == '0) begin
          state_nxt = ST_CHECK;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end

      ST_CHECK: begin
        if (mismatch) begin
          err_nxt = err_count + 1'b1;
          // Only the very first failing vector is recorded.
          if (err_count == '0) begin
            ffa_nxt = a;
            ffb_nxt = b;
          end
        end
        if (idx == '1) begin
          // Last vector: hold a/b on it so the final pair stays visible.
          state_nxt = ST_DONE;
        end else begin
          idx_nxt = idx + 1'b1;
          if (SETTLE == 0) begin
            state_nxt = ST_CHECK;
          end else begin
            state_nxt = ST_SETTLE;
            cnt_nxt   = CNT_INIT;
          end
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cmp_sweep_driver.sv
module tb_cmp_sweep_driver;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  int   mode  = 0;   // 0: correct comparator, 1: eq stuck-at-0, 2: gt/lt swapped

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  // DUT 0: WIDTH=2, SETTLE=1
  logic [1:0] a0, b0, ffa0, ffb0;
  logic [4:0] err0;
  logic       gt0, eq0, lt0, busy0, done0, pass0;
  // DUT 1: WIDTH=2, SETTLE=0
  logic [1:0] a1, b1, ffa1, ffb1;
  logic [4:0] err1;
  logic       gt1, eq1, lt1, busy1, done1, pass1;
  // DUT 2: WIDTH=3, SETTLE=1
  logic [2:0] a2, b2, ffa2, ffb2;
  logic [6:0] err2;
  logic       gt2, eq2, lt2, busy2, done2, pass2;

  // Comparator under test, with selectable planted faults.
  function automatic logic [2:0] fake_cmp(input int x, input int y, input int m);
    logic g, e, l;
    g = (x > y);
    e = (x == y);
    l = (x < y);
    case (m)
      1:       return {g, 1'b0, l};
      2:       return {l, e, g};
      default: return {g, e, l};
    endcase
  endfunction

  always_comb {gt0, eq0, lt0} = fake_cmp(int'(a0), int'(b0), mode);
  always_comb {gt1, eq1, lt1} = fake_cmp(int'(a1), int'(b1), mode);
  always_comb {gt2, eq2, lt2} = fake_cmp(int'(a2), int'(b2), mode);

  cmp_sweep_driver #(.WIDTH(2), .SETTLE(1)) u_dut0 (
    .clock(clock), .reset(reset), .start(start), .a(a0), .b(b0),
    .dut_gt(gt0), .dut_eq(eq0), .dut_lt(lt0), .busy(busy0), .done(done0),
    .pass(pass0), .err_count(err0), .first_fail_a(ffa0), .first_fail_b(ffb0)
  );

  cmp_sweep_driver #(.WIDTH(2), .SETTLE(0)) u_dut1 (
    .clock(clock), .reset(reset), .start(start), .a(a1), .b(b1),
    .dut_gt(gt1), .dut_eq(eq1), .dut_lt(lt1), .busy(busy1), .done(done1),
    .pass(pass1), .err_count(err1), .first_fail_a(ffa1), .first_fail_b(ffb1)
  );

  cmp_sweep_driver #(.WIDTH(3), .SETTLE(1)) u_dut2 (
    .clock(clock), .reset(reset), .start(start), .a(a2), .b(b2),
    .dut_gt(gt2), .dut_eq(eq2), .dut_lt(lt2), .busy(busy2), .done(done2),
    .pass(pass2), .err_count(err2), .first_fail_a(ffa2), .first_fail_b(ffb2)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Pulse start and count edges until each done rises (-1 if it never does).
  // Optionally re-pulse start mid-sweep, or assert reset mid-sweep and check the abort.
  task automatic run_sweep(input int repulse_at, input int reset_at,
                           output int c0, output int c1, output int c2);
    c0 = -1; c1 = -1; c2 = -1;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    check("done_clear_on_start", int'(done0), 0);
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clock);
      if (done0 && c0 < 0) c0 = cyc;
      if (done1 && c1 < 0) c1 = cyc;
      if (done2 && c2 < 0) c2 = cyc;
      start = (cyc == repulse_at);
      if (cyc == reset_at) begin
        reset = 1'b1;
        @(negedge clock);
        check("rst_mid_busy", int'(busy0), 0);
        check("rst_mid_done", int'(done0), 0);
        check("rst_mid_a",    int'(a0), 0);
        check("rst_mid_b",    int'(b0), 0);
        check("rst_mid_err",  int'(err0), 0);
        check("rst_mid_ffb",  int'(ffb0), 0);
        reset = 1'b0;
        break;
      end
      if (c0 >= 0 && c1 >= 0 && c2 >= 0) break;
    end
    start = 1'b0;
  endtask

  int c0, c1, c2;

  initial begin
    // Reset state
    repeat (3) @(negedge clock);
    check("rst_busy", int'(busy0), 0);
    check("rst_done", int'(done0), 0);
    check("rst_pass", int'(pass0), 0);
    check("rst_err",  int'(err0), 0);
    check("rst_a",    int'(a0), 0);
    check("rst_b",    int'(b0), 0);
    check("rst_ffa",  int'(ffa0), 0);
    reset = 1'b0;
    @(negedge clock);

    // Correct comparator
    mode = 0;
    run_sweep(0, 0, c0, c1, c2);
    check("ok_cycles_w2s1", c0, 32);
    check("ok_cycles_w2s0", c1, 16);
    check("ok_cycles_w3s1", c2, 128);
    check("ok_err",   int'(err0), 0);
    check("ok_pass",  int'(pass0), 1);
    check("ok_busy",  int'(busy0), 0);
    check("ok_a",     int'(a0), 3);
    check("ok_b",     int'(b0), 3);
    check("ok_pass1", int'(pass1), 1);
    check("ok_err2",  int'(err2), 0);
    check("ok_pass2", int'(pass2), 1);
    repeat (4) @(negedge clock);
    check("ok_done_sticky", int'(done0), 1);
    check("ok_a_hold",      int'(a0), 3);

    // eq stuck-at-0: every a==b vector fails
    mode = 1;
    run_sweep(0, 0, c0, c1, c2);
    check("eq0_cycles", c0, 32);
    check("eq0_err",    int'(err0), 4);
    check("eq0_pass",   int'(pass0), 0);
    check("eq0_ffa",    int'(ffa0), 0);
    check("eq0_ffb",    int'(ffb0), 0);
    check("eq0_err1",   int'(err1), 4);
    check("eq0_err2",   int'(err2), 8);

    // gt/lt swapped: every a!=b vector fails, first is (0,1)
    mode = 2;
    run_sweep(0, 0, c0, c1, c2);
    check("swap_cycles", c0, 32);
    check("swap_err",    int'(err0), 12);
    check("swap_pass",   int'(pass0), 0);
    check("swap_ffa",    int'(ffa0), 0);
    check("swap_ffb",    int'(ffb0), 1);
    check("swap_err2",   int'(err2), 56);
    check("swap_ffb2",   int'(ffb2), 1);

    // start re-pulsed mid-sweep is ignored
    run_sweep(5, 0, c0, c1, c2);
    check("repulse_cycles", c0, 32);
    check("repulse_err",    int'(err0), 12);
    check("repulse_ffb",    int'(ffb0), 1);

    // Reset 10 cycles into a failing sweep, then a clean full sweep
    run_sweep(0, 10, c0, c1, c2);
    mode = 0;
    run_sweep(0, 0, c0, c1, c2);
    check("post_rst_cycles", c0, 32);
    check("post_rst_err",    int'(err0), 0);
    check("post_rst_pass",   int'(pass0), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cmp_sweep_driver.md
Name: cmp_sweep_driver

Overview:
- Synthesizable stimulus-and-check engine for combinational magnitude comparators. It drives the operand side of the comparator interface; the comparator under test sits on the other side.
- Steps exhaustively through every (a, b) operand pair, waits a settle interval, and samples the comparator's gt/eq/lt outputs. It checks each sample against a golden model and counts mismatches.
- Sits beside the comparator blocks as an on-chip self-test, replacing hand-written vector lists.

Parameters:
- WIDTH, 2, operand width in bits; sweep covers 2^(2*WIDTH) vectors.
- SETTLE, 1, idle cycles between driving a vector and sampling the result; 0 allowed.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a sweep; sampled only in IDLE or DONE.
- a  output  WIDTH  operand A to the comparator.
- b  output  WIDTH  operand B to the comparator.
- dut_gt  input  1  comparator result, A > B.
- dut_eq  input  1  comparator result, A == B.
- dut_lt  input  1  comparator result, A < B.
- busy  output  1  high while the sweep runs (SETTLE or CHECK state).
- done  output  1  high in DONE; sticky until start or reset.
- pass  output  1  done && err_count == 0.
- err_count  output  2*WIDTH+1  number of mismatching vectors.
- first_fail_a  output  WIDTH  A of the first mismatching vector.
- first_fail_b  output  WIDTH  B of the first mismatching vector.

Behaviour:
- Reset: state IDLE; idx, a, b, err_count, first_fail_a/b, settle counter all 0; busy, done, pass all 0. Reset mid-sweep aborts immediately; no partial result survives.
- idx is 2*WIDTH bits; a = idx[2W-1:W], b = idx[W-1:0]. a and b are registered and are driven directly from idx.
- IDLE/DONE, start=1 → idx ← 0, err_count ← 0, first_fail ← 0, done ← 0.
  - Go to SETTLE with cnt ← SETTLE-1, or straight to CHECK when SETTLE == 0.
- SETTLE: cnt decrements each cycle; when cnt == 0 go to CHECK.
- CHECK, one cycle: sample dut_* and compare with golden {a>b, a==b, a<b}; any bit differing is a mismatch.
  - On mismatch: err_count++. If err_count was 0, capture first_fail_a/b ← a/b.
  - If idx == all-ones, go to DONE and leave idx unchanged.
  - Otherwise idx++ (a/b update on the same edge) and go to SETTLE, or CHECK if SETTLE == 0.
- Each vector takes SETTLE+1 cycles. For WIDTH=2, SETTLE=1, done rises after the 32nd edge following the edge that sampled start.
- start while busy is ignored, with no restart and no effect on the result.
- DONE: a/b hold the last vector. start re-runs a full sweep and clears the previous results.
- err_count cannot overflow; its maximum value is 2^(2W), which fits in 2W+1 bits.
- Simultaneous reset and start: reset wins.

Decomposition:
- Shared package cmp_pkg:
  - state enum {IDLE, SETTLE, CHECK, DONE};
  - localparam NVEC = 1 << (2*WIDTH);
  - encoding of the result triple {gt, eq, lt}.
- Sub-module cmp_golden: combinational, inputs a and b, outputs exp_gt, exp_eq, exp_lt. It is the sole golden model and is reusable by other benches.

Test Plan:
- Correct comparator, WIDTH=2, SETTLE=1, start pulsed → done=1 after 32 cycles, err_count=0, pass=1, a=3, b=3 held.
- DUT with eq stuck-at-0 → err_count=4, pass=0, first_fail_a=0, first_fail_b=0.
- DUT with gt and lt swapped → err_count=12, first_fail_a=0, first_fail_b=1.
- Reset asserted 10 cycles into a sweep → next cycle IDLE, busy=0, a=b=0, err_count=0; a new start completes a normal 32-cycle sweep.
- start re-pulsed at cycle 5 of a sweep → ignored; done still at cycle 32 with an identical err_count.
- SETTLE=0 → done after 16 cycles; WIDTH=3, SETTLE=1 → 64 vectors, done after 128 cycles, err_count=0 with a correct DUT.
